// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer width rule and Gray/binary conversion.
// Functions operate on the widest legal pointer; callers zero-extend in and truncate out.
package fifo_pkg;

  localparam int unsigned MaxAddrW = 12;
  localparam int unsigned MaxPtrW  = MaxAddrW + 1;

  // Pointer width carries one wrap bit above the RAM address.
  function automatic int unsigned ptr_w(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [MaxPtrW-1:0] bin2gray(input logic [MaxPtrW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended Gray input decodes correctly since the extension bits stay 0.
  function automatic logic [MaxPtrW-1:0] gray2bin(input logic [MaxPtrW-1:0] g);
    logic [MaxPtrW-1:0] b;
    b[MaxPtrW-1] = g[MaxPtrW-1];
    for (int i = int'(MaxPtrW) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Flop chain for a Gray-coded pointer crossing into this clock domain.
// Stages = 0 gives a pure pass-through for synchronous FIFOs.
module gray_ptr_sync #(
  parameter int unsigned Width  = 4,
  parameter int unsigned Stages = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Stages == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q_o = d_i;
  end else begin : g_chain
    logic [Width-1:0] sync_q [Stages];
    logic [Width-1:0] sync_d [Stages];

    // Shift each stage from its predecessor.
    always_comb begin
      sync_d[0] = d_i;
      for (int i = 1; i < int'(Stages); i++) begin
        sync_d[i] = sync_q[i-1];
      end
    end

    // Synchronous active-low reset clears every stage.
    always_ff @(posedge clk) begin
      for (int i = 0; i < int'(Stages); i++) begin
        if (!rst_n) begin
          sync_q[i] <= '0;
        end else begin
          sync_q[i] <= sync_d[i];
        end
      end
    end

    assign q_o = sync_q[Stages-1];
  end

endmodule

// File: rtl/fifo_write_ctrl.sv
// Write-side FIFO controller: binary/Gray write pointers, full, almost-full,
// level and sticky overflow, against an optionally synchronised Gray read pointer.
module fifo_write_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 3,
  parameter int unsigned SYNC_STAGES = 0,
  parameter int unsigned AF_THRESH   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH:0]   read_pointer_gray,
  input  logic                  overflow_clear,
  output logic                  write_enable_out,
  output logic [ADDR_WIDTH-1:0] write_pointer,
  output logic [ADDR_WIDTH:0]   write_pointer_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow
);

  localparam int unsigned PtrW = ptr_w(ADDR_WIDTH);
  localparam logic [PtrW-1:0] AfThresh = PtrW'(AF_THRESH);

  logic [PtrW-1:0] wbin_q, wbin_d;
  logic [PtrW-1:0] wgray_q, wgray_d;
  logic            overflow_q, overflow_d;
  logic [PtrW-1:0] rptr_s;
  logic [PtrW-1:0] rbin;

  gray_ptr_sync #(
    .Width  (PtrW),
    .Stages (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (read_pointer_gray),
    .q_o   (rptr_s)
  );

  // Status from registered write pointer and the (possibly delayed) read pointer.
  always_comb begin
    rbin             = PtrW'(gray2bin(MaxPtrW'(rptr_s)));
    // Full when the top two Gray bits differ and the rest match.
    full             = (wgray_q == {~rptr_s[PtrW-1:PtrW-2], rptr_s[PtrW-3:0]});
    level            = wbin_q - rbin;
    almost_full      = (level >= AfThresh);
    write_enable_out = write_enable & ~full & rst_n;
  end

  // Next-state: advance on accepted writes; overflow set beats clear.
  always_comb begin
    wbin_d     = wbin_q + {{(PtrW-1){1'b0}}, write_enable_out};
    wgray_d    = PtrW'(bin2gray(MaxPtrW'(wbin_d)));
    overflow_d = overflow_q;
    if (write_enable && full) begin
      overflow_d = 1'b1;
    end else if (overflow_clear) begin
      overflow_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbin_q     <= '0;
      wgray_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wbin_q     <= wbin_d;
      wgray_q    <= wgray_d;
      overflow_q <= overflow_d;
    end
  end

  assign write_pointer      = wbin_q[ADDR_WIDTH-1:0];
  assign write_pointer_gray = wgray_q;
  assign overflow           = overflow_q;

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Directed bench for fifo_write_ctrl: a SYNC_STAGES=0 instance for most steps
// and a SYNC_STAGES=2 instance for the read-pointer latency step.
module tb_fifo_write_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance 0: ADDR_WIDTH=3, SYNC_STAGES=0, AF_THRESH=6
  logic       rst_n, we, oc;
  logic [3:0] rp;
  logic       weo, full, af, ovf;
  logic [2:0] wp;
  logic [3:0] wpg, lvl;

  // Instance 2: ADDR_WIDTH=3, SYNC_STAGES=2, AF_THRESH=6
  logic       rst2_n, we2, oc2;
  logic [3:0] rp2;
  logic       weo2, full2, af2, ovf2;
  logic [2:0] wp2;
  logic [3:0] wpg2, lvl2;

  fifo_write_ctrl #(
    .ADDR_WIDTH  (3),
    .SYNC_STAGES (0),
    .AF_THRESH   (6)
  ) u_dut0 (
    .clk                (clk),
    .rst_n              (rst_n),
    .write_enable       (we),
    .read_pointer_gray  (rp),
    .overflow_clear     (oc),
    .write_enable_out   (weo),
    .write_pointer      (wp),
    .write_pointer_gray (wpg),
    .full               (full),
    .almost_full        (af),
    .level              (lvl),
    .overflow           (ovf)
  );

  fifo_write_ctrl #(
    .ADDR_WIDTH  (3),
    .SYNC_STAGES (2),
    .AF_THRESH   (6)
  ) u_dut2 (
    .clk                (clk),
    .rst_n              (rst2_n),
    .write_enable       (we2),
    .read_pointer_gray  (rp2),
    .overflow_clear     (oc2),
    .write_enable_out   (weo2),
    .write_pointer      (wp2),
    .write_pointer_gray (wpg2),
    .full               (full2),
    .almost_full        (af2),
    .level              (lvl2),
    .overflow           (ovf2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] g(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  initial begin
    rst_n = 1'b0; we = 1'b1; oc = 1'b0; rp = 4'd0;
    rst2_n = 1'b0; we2 = 1'b0; oc2 = 1'b0; rp2 = 4'd0;
    #1;
    chk("weo_in_reset", weo, 0);
    tick();
    tick();
    chk("rst_wp", wp, 0);
    chk("rst_wpg", wpg, 0);
    chk("rst_level", lvl, 0);
    chk("rst_full", full, 0);
    chk("rst_af", af, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_weo", weo, 0);

    // 1/3: fill 8 entries; almost_full from level 6, full at 8.
    rst_n = 1'b1;
    we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("fill_wp", wp, i);
      chk("fill_level", lvl, i);
      chk("fill_weo", weo, 1);
      chk("fill_full", full, 0);
      chk("fill_af", af, (i >= 6) ? 1 : 0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("ovr_weo", weo, 0);
      chk("ovr_full", full, 1);
      chk("ovr_wp", wp, 0);
      chk("ovr_level", lvl, 8);
      tick();
      chk("ovr_ovf", ovf, 1);
    end
    chk("full_wpg", wpg, 4'b1100);
    chk("full_af", af, 1);

    // 2: each read step frees one slot, one write refills it.
    for (int k = 1; k <= 8; k++) begin
      rp = g(k);
      #1;
      chk("step_full_drop", full, 0);
      chk("step_weo", weo, 1);
      chk("step_level7", lvl, 7);
      tick();
      chk("step_full_back", full, 1);
      chk("step_level8", lvl, 8);
      chk("step_wp", wp, (8 + k) % 8);
    end
    chk("wrap_wpg", wpg, 0);
    chk("wrap_wp", wp, 0);

    // 3: advance read pointer by 3 -> level 5, almost_full clear.
    we = 1'b0;
    rp = g(11);
    #1;
    chk("rd3_level", lvl, 5);
    chk("rd3_af", af, 0);
    chk("rd3_full", full, 0);
    tick();

    // 5: clear alone, then clear together with write-while-full.
    oc = 1'b1;
    tick();
    oc = 1'b0;
    chk("clr_ovf", ovf, 0);
    we = 1'b1;
    tick(); tick(); tick();
    we = 1'b0;
    chk("refill_full", full, 1);
    chk("refill_ovf", ovf, 0);
    we = 1'b1; oc = 1'b1;
    #1;
    chk("setclr_weo", weo, 0);
    tick();
    we = 1'b0; oc = 1'b0;
    chk("setclr_ovf", ovf, 1);

    // 6: bring level to 5, then reset with write held high.
    rp = g(14);
    #1;
    chk("pre_rst_level", lvl, 5);
    tick();
    rst_n = 1'b0; we = 1'b1; rp = 4'd0;
    #1;
    chk("mid_rst_weo", weo, 0);
    tick();
    chk("mid_rst_wp", wp, 0);
    chk("mid_rst_wpg", wpg, 0);
    chk("mid_rst_level", lvl, 0);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_af", af, 0);
    chk("mid_rst_ovf", ovf, 0);
    rst_n = 1'b1; we = 1'b0;

    // 4: two-stage sync delays the full release by two edges.
    rst2_n = 1'b1;
    we2 = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("s2_full", full2, 1);
    chk("s2_level", lvl2, 8);
    rp2 = g(1);
    #1;
    chk("s2_hold0_full", full2, 1);
    chk("s2_hold0_weo", weo2, 0);
    tick();
    chk("s2_hold1_full", full2, 1);
    chk("s2_hold1_weo", weo2, 0);
    tick();
    chk("s2_drop_full", full2, 0);
    chk("s2_drop_weo", weo2, 1);
    tick();
    we2 = 1'b0;
    chk("s2_accept_wp", wp2, 1);
    chk("s2_accept_full", full2, 1);
    chk("s2_accept_level", lvl2, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_write_ctrl.md
Name: fifo_write_ctrl

Overview:
Parametrised write-side controller for the team's FIFOs, and the successor to the fixed 8-entry write counter. It owns the binary write address, the registered Gray write pointer, and the full/almost-full/level/overflow status. The read pointer arrives as Gray code and passes through an optional N-stage synchroniser, so the same block serves synchronous FIFOs and async write domains. It sits between the producer and the FIFO RAM write port.

Parameters:
ADDR_WIDTH, 3, RAM address bits; depth = 2**ADDR_WIDTH (legal range 2..12)
SYNC_STAGES, 0, flops on read_pointer_gray before use; 0 = use directly, else 2..4
AF_THRESH, 6, almost_full asserts when level >= AF_THRESH (range 1..2**ADDR_WIDTH)

Ports:
clk  in  1  write clock, rising edge
rst_n  in  1  synchronous, active-low reset
write_enable  in  1  producer write request
read_pointer_gray  in  ADDR_WIDTH+1  read pointer in Gray code, from read side
overflow_clear  in  1  clears sticky overflow
write_enable_out  out  1  qualified RAM write strobe
write_pointer  out  ADDR_WIDTH  RAM write address (binary, low bits)
write_pointer_gray  out  ADDR_WIDTH+1  registered Gray write pointer to read side
full  out  1  FIFO full
almost_full  out  1  level >= AF_THRESH
level  out  ADDR_WIDTH+1  entries occupied, as seen by write side (0..depth)
overflow  out  1  sticky: write attempted while full

Behaviour:
- Reset (rst_n low at a clk edge): binary pointer, Gray pointer, all sync flops and overflow = 0. Outputs follow: full=0, level=0, almost_full=0, write_enable_out=0 (write_enable is ignored during reset). Reset mid-stream discards all state in one cycle, with no partial increment.
- Pointer: internal binary wbin is ADDR_WIDTH+1 bits and wraps modulo 2**(ADDR_WIDTH+1). write_pointer = wbin[ADDR_WIDTH-1:0].
- write_enable_out = write_enable & ~full & rst_n. This is combinational, same cycle as the request.
- On a clk edge with write_enable_out=1: wbin <= wbin+1 and write_pointer_gray <= (wbin+1) ^ ((wbin+1)>>1). Both are registered, so write_pointer_gray has exactly one bit toggling per write and no glitches.
- Sync: rptr_s = read_pointer_gray delayed by SYNC_STAGES clk cycles; SYNC_STAGES=0 means rptr_s = read_pointer_gray.
- full = (write_pointer_gray == {~rptr_s[ADDR_WIDTH:ADDR_WIDTH-1], rptr_s[ADDR_WIDTH-2:0]}). Combinational from registers plus rptr_s.
- level = wbin - gray2bin(rptr_s), computed modulo 2**(ADDR_WIDTH+1). The result is always in 0..depth, and level == depth exactly when full.
- almost_full = (level >= AF_THRESH). With AF_THRESH = depth, almost_full equals full.
- Write while full: nothing is written and the pointer holds. overflow <= 1 at that edge.
- overflow_clear: overflow <= 0. If overflow_clear and a write-while-full occur in the same cycle, set wins (overflow <= 1).
- Read pointer advance while full: with SYNC_STAGES=0, full drops in the same cycle and a write in that same cycle is accepted. With SYNC_STAGES=S, full drops S cycles after read_pointer_gray changes.
- Wrap: after 2**(ADDR_WIDTH+1) accepted writes, wbin returns to 0 and the Gray pointer returns to 0. No special casing is needed.
- Status is pessimistic under sync latency: full and level may lag reads, but never lag writes. Overflow of the RAM is therefore impossible.

Decomposition:
- Package fifo_pkg:
  - function bin2gray(w)
  - function gray2bin(w)
  - localparam rule PTR_W = ADDR_WIDTH+1
- One sub-module, gray_ptr_sync: parametrised width/stages flop chain, with a pass-through when stages=0. Reused later by the read-side controller.
- Everything else stays flat in fifo_write_ctrl.

Test Plan:
1. ADDR_WIDTH=3, SYNC_STAGES=0, rptr=0. Apply 8 single-cycle writes, then 8 more → write_pointer 0..7 then holds at 0. write_pointer_gray ends at 4'b1100, level=8, full=1, overflow=1, and write_enable_out stays 0 on the extra 8.
2. From full, step read_pointer (binary 1..8, fed as Gray), each step followed by one write → full drops the same cycle, one write is accepted, and full reasserts. After the loop wbin=16→0, write_pointer_gray=0, level=8.
3. AF_THRESH=6: fill from empty → almost_full rises on the edge where level goes 5→6, and full rises on 7→8. Advance rptr by 3 → level=5 and almost_full=0.
4. SYNC_STAGES=2, full, then change rptr Gray by one bit → full stays 1 for exactly 2 cycles and drops in the 3rd. A write held high is accepted in that 3rd cycle.
5. Overflow: set overflow, then pulse overflow_clear alone → 0 next cycle. Pulse overflow_clear together with a write-while-full → overflow stays 1.
6. Reset mid-stream: reach level=5, then assert rst_n=0 for 1 cycle with write_enable=1 → next cycle all pointers, level, full, almost_full and overflow are 0, and write_enable_out=0 during reset.
